spike_rate_monitor: RTL and testbench
=====================================

Name: spike_rate_monitor

Overview:
Downstream stage of the LIF neuron: consumes the neuron's 1-cycle spike pulse and 8-bit membrane state, and measures activity over a programmable window of clock cycles. At each window end it publishes spike count and minimum inter-spike interval (ISI) through a single-entry valid/ready output buffer. Used on-chip to read neuron firing rate without sampling every spike on pins.

Parameters:
WIN_W, 16, width of window-length input and elapsed-cycle counter
CNT_W, 8, width of spike-count result (saturating)
ISI_W, 8, width of ISI counter and result (saturating)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable_i  in  1  1 = run windows back-to-back; 0 = stop/abort
win_len_i  in  WIN_W  window length in cycles, sampled at each window start; 0 treated as 1
spike_i  in  1  spike pulse from LIF; each cycle high = one spike
state_i  in  8  LIF membrane state (unsigned)
rate_o  out  CNT_W  spikes counted in last completed window
isi_min_o  out  ISI_W  minimum ISI (cycles) in last window; all-ones = fewer than 2 spikes
peak_o  out  8  max state_i in last window (SPIKE_PEAK_EN only, else 0)
out_valid_o  out  1  result buffer holds unconsumed result
out_ready_i  in  1  consumer accepts result when high with out_valid_o
overrun_o  out  1  sticky: a window result was dropped
active_o  out  1  high while in RUN

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; rate_o=0, isi_min_o=all-ones, peak_o=0, out_valid_o=0, overrun_o=0, active_o=0; all internal counters 0.
- FSM states: IDLE, RUN.
- IDLE: enable_i=1 -> latch win_len (0->1), clear accumulators, clear overrun_o, go RUN next cycle. Spikes in IDLE ignored.
- RUN, per cycle: elapsed++; if spike_i: count++ (saturate at 2^CNT_W-1). ISI counter increments every cycle (saturates at all-ones), resets to 1 on spike; on spike, if an earlier spike exists in this window, isi_min = min(isi_min, isi_cnt). ISI distance is never carried across windows.
- Window end (elapsed == win_len-1, spike that cycle included): result formed. If buffer free (out_valid_o=0, or out_valid_o=1 and out_ready_i=1 same cycle) load rate_o/isi_min_o/peak_o and set out_valid_o next cycle; else drop result, set overrun_o. Latency: result visible 1 cycle after last window cycle.
- After window end: enable_i=1 -> relatch win_len_i, start next window the following cycle, no gap; enable_i=0 -> IDLE.
- enable_i=0 mid-window: abort to IDLE next cycle, partial window discarded, buffer untouched.
- Handshake: out_valid_o held and outputs stable until out_valid_o&out_ready_i; then out_valid_o clears unless a new result loads same cycle.
- Two spikes on consecutive cycles -> ISI 1. win_len=1 -> every cycle is a window; isi_min_o always all-ones.
- active_o = (FSM==RUN).

Optional Feature:
SPIKE_PEAK_EN: when defined, tracks max state_i per RUN window (reset to 0 at window start, compared every RUN cycle incl. last) and loads it into peak_o with other results. When undefined, no peak register, peak_o tied to 0.

Decomposition:
- Shared package (snn_pkg): FSM state typedef (IDLE, RUN), sat-all-ones constants for CNT_W/ISI_W, default widths.
- One sub-module natural: spike_isi_tracker (ISI counter, first-spike flag, running min); counting/FSM/buffer stay in top.

Test Plan:
- Reset mid-RUN with out_valid_o=1 -> all outputs to reset values immediately, isi_min_o=0xFF.
- win_len=10, spikes at cycles 2,5,6 of window, ready=1 -> rate_o=3, isi_min_o=1, valid 1 cycle after cycle 9.
- win_len=4, single spike -> rate_o=1, isi_min_o=0xFF; spike every cycle win_len=300 -> rate_o=255 (saturated), isi_min_o=1.
- win_len=5, out_ready_i=0 for 3 windows -> first result held stable, overrun_o=1 after 2nd window end; ready=1 -> first result consumed.
- enable_i dropped at cycle 3 of win_len=8 -> IDLE, no valid; re-enable -> overrun_o cleared, new window from 0.
- SPIKE_PEAK_EN, state_i ramps 0..50 then 20 in win_len=60 -> peak_o=50; without macro peak_o=0.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-neuron monitor blocks.
// Holds the monitor FSM encoding, default widths and saturation values.
// No logic; imported by the monitor top and its ISI tracker.
package snn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIN_W = 16;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_ISI_W = 8;

  // All-ones saturation values for the default result widths
  localparam logic [DEF_CNT_W-1:0] CNT_SAT = '1;
  localparam logic [DEF_ISI_W-1:0] ISI_SAT = '1;

endpackage

// File: rtl/spike_isi_tracker.sv
// Tracks inter-spike distance and its running minimum within one window.
// Latency: isi_min_nxt_o is combinational and includes the current cycle's spike.
// Backpressure: none; updates every RUN cycle, cleared synchronously by clr_i.
module spike_isi_tracker
  import snn_pkg::*;
#(
  parameter int ISI_W = DEF_ISI_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic             spike_i,
  output logic [ISI_W-1:0] isi_min_nxt_o
);

  localparam logic [ISI_W-1:0] SAT = '1;
  localparam logic [ISI_W-1:0] ONE = ISI_W'(1);

  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d, isi_cnt_upd;
  logic [ISI_W-1:0] isi_min_q, isi_min_d, isi_min_upd;
  logic             seen_q, seen_d;

  // Per-cycle update; the clear is applied after the update so the closing
  // cycle of a window still contributes to the published minimum.
  always_comb begin
    isi_cnt_upd = spike_i ? ONE : ((isi_cnt_q == SAT) ? SAT : isi_cnt_q + ONE);
    isi_min_upd = (spike_i && seen_q && (isi_cnt_q < isi_min_q)) ? isi_cnt_q : isi_min_q;
    isi_min_nxt_o = run_i ? isi_min_upd : isi_min_q;
    isi_cnt_d = isi_cnt_q;
    isi_min_d = isi_min_q;
    seen_d    = seen_q;
    if (clr_i) begin
      isi_cnt_d = '0;
      isi_min_d = SAT;
      seen_d    = 1'b0;
    end else if (run_i) begin
      isi_cnt_d = isi_cnt_upd;
      isi_min_d = isi_min_upd;
      seen_d    = seen_q | spike_i;
    end
  end

  // Tracker state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_cnt_q <= '0;
      isi_min_q <= SAT;
      seen_q    <= 1'b0;
    end else begin
      isi_cnt_q <= isi_cnt_d;
      isi_min_q <= isi_min_d;
      seen_q    <= seen_d;
    end
  end

endmodule

// File: rtl/spike_rate_monitor.sv
// Windowed spike-rate / min-ISI monitor; SPIKE_PEAK_EN adds per-window peak state.
// Latency: result visible 1 cycle after the last cycle of a window.
// Backpressure: single-entry valid/ready buffer; a result that finds it full is dropped and overrun_o sticks.
module spike_rate_monitor
  import snn_pkg::*;
#(
  parameter int WIN_W = DEF_WIN_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ISI_W = DEF_ISI_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic [WIN_W-1:0] win_len_i,
  input  logic             spike_i,
  input  logic [7:0]       state_i,
  output logic [CNT_W-1:0] rate_o,
  output logic [ISI_W-1:0] isi_min_o,
  output logic [7:0]       peak_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             overrun_o,
  output logic             active_o
);

  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_len_q, win_len_d;
  logic [WIN_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_upd;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic [ISI_W-1:0] isi_out_q, isi_out_d, isi_min_nxt;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             run, last, start, win_clr, load;

  spike_isi_tracker #(.ISI_W(ISI_W)) u_isi (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_i        (run),
    .clr_i        (win_clr),
    .spike_i      (spike_i),
    .isi_min_nxt_o(isi_min_nxt)
  );

  // FSM next state, window counting and result-buffer handshake
  always_comb begin
    run     = (state_q == RUN);
    last    = run && (elapsed_q == win_len_q - WIN_ONE);
    start   = (state_q == IDLE) && enable_i;
    win_clr = start || last;
    // A slot is free if empty or being drained this very cycle
    load    = last && (!out_valid_q || out_ready_i);
    cnt_upd = (spike_i && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;

    state_d     = state_q;
    win_len_d   = win_len_q;
    elapsed_d   = elapsed_q;
    cnt_d       = cnt_q;
    rate_d      = rate_q;
    isi_out_d   = isi_out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE:    if (enable_i)  state_d = RUN;
      RUN:     if (!enable_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (start || (last && enable_i))
      win_len_d = (win_len_i == '0) ? WIN_ONE : win_len_i;

    if (win_clr) begin
      elapsed_d = '0;
      cnt_d     = '0;
    end else if (run) begin
      elapsed_d = elapsed_q + WIN_ONE;
      cnt_d     = cnt_upd;
    end

    if (start)
      overrun_d = 1'b0;
    else if (last && !load)
      overrun_d = 1'b1;

    if (load) begin
      rate_d      = cnt_upd;
      isi_out_d   = isi_min_nxt;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State, counters and result buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_len_q   <= '0;
      elapsed_q   <= '0;
      cnt_q       <= '0;
      rate_q      <= '0;
      isi_out_q   <= '1;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_len_q   <= win_len_d;
      elapsed_q   <= elapsed_d;
      cnt_q       <= cnt_d;
      rate_q      <= rate_d;
      isi_out_q   <= isi_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef SPIKE_PEAK_EN
  logic [7:0] peak_acc_q, peak_acc_d, peak_upd, peak_q, peak_d;

  // Running maximum of membrane state, published with the other results
  always_comb begin
    peak_upd   = (state_i > peak_acc_q) ? state_i : peak_acc_q;
    peak_acc_d = peak_acc_q;
    peak_d     = peak_q;
    if (win_clr)  peak_acc_d = '0;
    else if (run) peak_acc_d = peak_upd;
    if (load)     peak_d = peak_upd;
  end

  // Peak accumulator and published peak
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_acc_q <= '0;
      peak_q     <= '0;
    end else begin
      peak_acc_q <= peak_acc_d;
      peak_q     <= peak_d;
    end
  end

  assign peak_o = peak_q;
`else
  logic unused_state;
  assign unused_state = ^state_i;
  assign peak_o       = '0;
`endif

  assign rate_o      = rate_q;
  assign isi_min_o   = isi_out_q;
  assign out_valid_o = out_valid_q;
  assign overrun_o   = overrun_q;
  assign active_o    = run;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed bench for spike_rate_monitor: table of per-cycle vectors plus hand sequences.
// Each vector drives inputs at the falling edge and checks outputs at the next falling edge.
// Covers reset, windows, saturation, win_len 0/1, backpressure/overrun, abort and peak.
module tb_spike_rate_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic [15:0] win_len_i;
  logic        spike_i;
  logic [7:0]  state_i;
  logic [7:0]  rate_o;
  logic [7:0]  isi_min_o;
  logic [7:0]  peak_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        overrun_o;
  logic        active_o;

`ifdef SPIKE_PEAK_EN
  localparam logic [7:0] EXP_PEAK = 8'd50;
`else
  localparam logic [7:0] EXP_PEAK = 8'd0;
`endif

  spike_rate_monitor #(.WIN_W(16), .CNT_W(8), .ISI_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable_i),
    .win_len_i  (win_len_i),
    .spike_i    (spike_i),
    .state_i    (state_i),
    .rate_o     (rate_o),
    .isi_min_o  (isi_min_o),
    .peak_o     (peak_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .overrun_o  (overrun_o),
    .active_o   (active_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [15:0] wl;
    logic        sp;
    logic        rdy;
    bit          cv;
    logic        ev, ea, eo;
    bit          cr;
    logic [7:0]  er, ei;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic void add(input logic en, input logic [15:0] wl, input logic sp,
                              input logic rdy, input bit cv, input logic ev, input logic ea,
                              input logic eo, input bit cr, input logic [7:0] er,
                              input logic [7:0] ei);
    vec_t r;
    r.en = en; r.wl = wl; r.sp = sp; r.rdy = rdy;
    r.cv = cv; r.ev = ev; r.ea = ea; r.eo = eo;
    r.cr = cr; r.er = er; r.ei = ei;
    tbl.push_back(r);
  endfunction

  task automatic check(input string name, input bit cv, input logic ev, input logic ea,
                       input logic eo, input bit cr, input logic [7:0] er,
                       input logic [7:0] ei, input logic [7:0] ep);
    bit bad;
    bad = 1'b0;
    nvec++;
    if (cv && (out_valid_o !== ev)) bad = 1'b1;
    if (active_o !== ea) bad = 1'b1;
    if (overrun_o !== eo) bad = 1'b1;
    if (cr && ((rate_o !== er) || (isi_min_o !== ei) || (peak_o !== ep))) bad = 1'b1;
    if (bad) begin
      nerr++;
      $display("FAIL %s: got vld=%0b act=%0b ovr=%0b rate=%0d isi=%0d peak=%0d, want vld=%0b act=%0b ovr=%0b rate=%0d isi=%0d peak=%0d",
               name, out_valid_o, active_o, overrun_o, rate_o, isi_min_o, peak_o,
               ev, ea, eo, er, ei, ep);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Window of 10 with spikes at 2,5,6, consumer always ready
    add(1, 10, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++)
      add(1, 10, (k == 2 || k == 5 || k == 6), 1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 10, 0, 1, 1, 1, 1, 0, 1, 3, 1);
    add(0, 10, 0, 1, 1, 0, 0, 0, 1, 3, 1);
    // Window of 4, one spike
    add(1, 4, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      add(1, 4, (k == 1), 1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 4, 0, 1, 1, 1, 1, 0, 1, 1, 8'hFF);
    add(0, 4, 0, 1, 1, 0, 0, 0, 1, 1, 8'hFF);
    // win_len 0 behaves as 1: every cycle closes a window, ISI never carried
    add(1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 1, 1, 1, 1, 0, 1, 1, 8'hFF);
    add(1, 0, 1, 1, 1, 1, 1, 0, 1, 1, 8'hFF);
    add(1, 0, 0, 1, 1, 1, 1, 0, 1, 0, 8'hFF);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    // Window of 5, consumer stalled for three windows
    add(1, 5, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      add(1, 5, (k == 0 || k == 2), 0, 1, 0, 1, 0, 0, 0, 0);
    add(1, 5, 0, 0, 1, 1, 1, 0, 1, 2, 2);
    for (int k = 0; k < 4; k++)
      add(1, 5, 1, 0, 1, 1, 1, 0, 1, 2, 2);
    add(1, 5, 1, 0, 1, 1, 1, 1, 1, 2, 2);
    for (int k = 0; k < 5; k++)
      add(1, 5, 0, 0, 1, 1, 1, 1, 1, 2, 2);
    add(1, 5, 0, 1, 1, 0, 1, 1, 1, 2, 2);
    add(0, 5, 0, 1, 1, 0, 0, 1, 1, 2, 2);
    // Abort at cycle 3 of an 8-cycle window, then a fresh 3-cycle window
    add(1, 8, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      add(1, 8, (k == 1), 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 8, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 8, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 8, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 3, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 3, 1, 1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 3, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 3, 0, 1, 1, 1, 1, 0, 1, 1, 8'hFF);
    add(0, 3, 0, 1, 1, 0, 0, 0, 1, 1, 8'hFF);

    rst_n = 1'b0; enable_i = 1'b0; win_len_i = '0; spike_i = 1'b0;
    state_i = '0; out_ready_i = 1'b0;
    #12;
    check("reset", 1, 0, 0, 0, 1, 0, 8'hFF, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      enable_i    = tbl[i].en;
      win_len_i   = tbl[i].wl;
      spike_i     = tbl[i].sp;
      out_ready_i = tbl[i].rdy;
      state_i     = '0;
      step();
      check($sformatf("tbl[%0d]", i), tbl[i].cv, tbl[i].ev, tbl[i].ea, tbl[i].eo,
            tbl[i].cr, tbl[i].er, tbl[i].ei, 8'd0);
    end

    // Spike every cycle over 300 cycles: count saturates, ISI is 1
    enable_i = 1'b1; win_len_i = 16'd300; spike_i = 1'b1; out_ready_i = 1'b1;
    step();
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 298) check("sat_before_end", 1, 0, 1, 0, 0, 0, 0, 0);
    end
    check("sat_result", 1, 1, 1, 0, 1, 8'd255, 8'd1, 0);
    enable_i = 1'b0; spike_i = 1'b0;
    step();
    check("sat_drain", 1, 0, 0, 0, 0, 0, 0, 0);

    // Membrane state ramps 0..50 then sits at 20 across a 60-cycle window
    enable_i = 1'b1; win_len_i = 16'd60; state_i = '0;
    step();
    for (int i = 0; i < 60; i++) begin
      state_i = (i <= 50) ? 8'(i) : 8'd20;
      step();
    end
    check("peak_result", 1, 1, 1, 0, 1, 8'd0, 8'hFF, EXP_PEAK);
    enable_i = 1'b0; state_i = '0;
    step();
    check("peak_drain", 1, 0, 0, 0, 0, 0, 0, 0);

    // Reset while running with a result held
    enable_i = 1'b1; win_len_i = 16'd2; out_ready_i = 1'b0; spike_i = 1'b0;
    step();
    spike_i = 1'b1;
    step();
    spike_i = 1'b0;
    step();
    step();
    check("pre_reset", 1, 1, 1, 0, 1, 8'd1, 8'hFF, 0);
    rst_n = 1'b0;
    #1;
    check("mid_reset", 1, 0, 0, 0, 1, 8'd0, 8'hFF, 0);
    enable_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
